// File: rtl/cache_req_ctrl.sv
// cache_req_ctrl: sequences one CPU request at a time into a bank of cache sets.
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   req_*             : CPU request (valid/ready, address, write flag, size, write data)
//   set_enable        : one-hot strobe to the addressed set, high for the single ISSUE cycle
//   set_write_enable  : 0=read, 1=write, 2=no-op
//   set_tag/.../n_ops : registered request fields and operation number presented to the set
//   set_out_data/miss/data_ready : reply from the selected set, honoured only in WAIT
//   resp_*            : CPU response (valid/ready, data, miss, error)
module cache_req_ctrl #(
   parameter int TIMEOUT  = 8,
   parameter int NUM_SETS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_addr,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic [63:0]         req_wdata,
   output logic [NUM_SETS-1:0] set_enable,
   output logic [2:0]          set_write_enable,
   output logic [23:0]         set_tag,
   output logic [5:0]          set_block_offset,
   output logic [1:0]          set_data_size,
   output logic [63:0]         set_write_data,
   output logic [31:0]         set_n_ops,
   input  logic [63:0]         set_out_data,
   input  logic                set_miss,
   input  logic                set_data_ready,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [63:0]         resp_data,
   output logic                resp_miss,
   output logic                resp_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [23:0]   tag_q;
   logic [1:0]    idx_q;
   logic [5:0]    off_q;
   logic [1:0]    size_q;
   logic          we_q;
   logic [63:0]   wdata_q;
   logic [31:0]   n_ops;
   logic [CW-1:0] wait_cnt;
   logic          accept;
   logic          misaligned;
   logic          timed_out;
   assign accept     = state == IDLE && req_valid;
   // access crosses the 64-byte block when offset + 2^size exceeds 64
   assign misaligned = {1'b0, req_addr[5:0]} + (7'd1 << req_size) > 7'd64;
   // wait_cnt counts completed WAIT cycles, so this is the TIMEOUT-th one
   assign timed_out  = wait_cnt == CW'(TIMEOUT - 1);
   assign set_tag          = tag_q;
   assign set_block_offset = off_q;
   assign set_data_size    = size_q;
   assign set_write_data   = wdata_q;
   assign set_n_ops        = n_ops;
   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : state_nx;
   always_comb begin
      state_nx = state == IDLE  ? (req_valid ? (misaligned ? RESP : ISSUE) : IDLE) :
                 state == ISSUE ? WAIT :
                 state == WAIT  ? (we_q || set_miss || set_data_ready || timed_out ? RESP : WAIT) :
                 resp_ready     ? IDLE : RESP;
   end
   always_comb begin
      req_ready        = state == IDLE;
      resp_valid       = state == RESP;
      set_enable       = state == ISSUE ? NUM_SETS'(1) << idx_q : '0;
      set_write_enable = state == ISSUE ? {2'b00, we_q} : 3'd2;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_q     <= '0;
         idx_q     <= '0;
         off_q     <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         n_ops     <= '0;
         wait_cnt  <= '0;
         resp_data <= '0;
         resp_miss <= 1'b0;
         resp_err  <= 1'b0;
      end else begin
         wait_cnt <= state == WAIT ? wait_cnt + CW'(1) : '0;
         if (accept) begin
            tag_q     <= req_addr[31:8];
            idx_q     <= req_addr[7:6];
            off_q     <= req_addr[5:0];
            size_q    <= req_size;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            n_ops     <= n_ops + 32'd1;
            resp_data <= '0;
            resp_miss <= 1'b0;
            resp_err  <= misaligned;
         end
         // miss outranks data_ready; writes only ever look at miss
         if (state == WAIT) begin
            if (set_miss)
               resp_miss <= 1'b1;
            else if (!we_q && set_data_ready)
               resp_data <= set_out_data;
            else if (!we_q && timed_out)
               resp_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cache_req_ctrl.sv
// tb_cache_req_ctrl: directed bench for cache_req_ctrl with a per-cycle timeline model.
//   Each request is turned into an expected timeline (IDLE, ISSUE, WAIT cycles, RESP hold)
//   from the transaction rules; a negedge process compares the DUT against it every cycle.
module tb_cache_req_ctrl;
   localparam int TIMEOUT  = 8;
   localparam int NUM_SETS = 4;
   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic [31:0]         req_addr = '0;
   logic                req_we = 1'b0;
   logic [1:0]          req_size = '0;
   logic [63:0]         req_wdata = '0;
   logic [NUM_SETS-1:0] set_enable;
   logic [2:0]          set_write_enable;
   logic [23:0]         set_tag;
   logic [5:0]          set_block_offset;
   logic [1:0]          set_data_size;
   logic [63:0]         set_write_data;
   logic [31:0]         set_n_ops;
   logic [63:0]         set_out_data = '0;
   logic                set_miss = 1'b0;
   logic                set_data_ready = 1'b0;
   logic                resp_valid;
   logic                resp_ready = 1'b0;
   logic [63:0]         resp_data;
   logic                resp_miss;
   logic                resp_err;
   cache_req_ctrl #(.TIMEOUT(TIMEOUT), .NUM_SETS(NUM_SETS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata),
      .set_enable(set_enable), .set_write_enable(set_write_enable), .set_tag(set_tag),
      .set_block_offset(set_block_offset), .set_data_size(set_data_size),
      .set_write_data(set_write_data), .set_n_ops(set_n_ops),
      .set_out_data(set_out_data), .set_miss(set_miss), .set_data_ready(set_data_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_miss(resp_miss), .resp_err(resp_err)
   );
   always #5 clk = ~clk;
   typedef struct {
      bit          v;
      bit          busy;
      bit          ready;
      bit          rvalid;
      logic [3:0]  en;
      logic [2:0]  we;
      logic [63:0] rdata;
      bit          rmiss;
      bit          rerr;
      logic [31:0] nops;
      logic [23:0] tag;
      logic [5:0]  off;
      logic [1:0]  size;
      logic [63:0] wdata;
   } exp_t;
   exp_t        tl [4096];
   int          cyc = 0;
   int          n_pass = 0;
   int          n_chk = 0;
   logic [31:0] m_nops = '0;
   int          cap_lat;
   logic [3:0]  cap_en;
   logic [2:0]  cap_we;
   logic [23:0] cap_tag;
   logic [63:0] cap_data;
   logic        cap_miss;
   logic        cap_err;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, a, e);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (cyc < 4096 && tl[cyc].v) begin
         chk("req_ready", 64'(req_ready), 64'(tl[cyc].ready));
         chk("resp_valid", 64'(resp_valid), 64'(tl[cyc].rvalid));
         chk("set_enable", 64'(set_enable), 64'(tl[cyc].en));
         chk("set_write_enable", 64'(set_write_enable), 64'(tl[cyc].we));
         chk("set_n_ops", 64'(set_n_ops), 64'(tl[cyc].nops));
         if (tl[cyc].busy) begin
            chk("set_tag", 64'(set_tag), 64'(tl[cyc].tag));
            chk("set_block_offset", 64'(set_block_offset), 64'(tl[cyc].off));
            chk("set_data_size", 64'(set_data_size), 64'(tl[cyc].size));
            chk("set_write_data", set_write_data, tl[cyc].wdata);
         end
         if (tl[cyc].rvalid) begin
            chk("resp_data", resp_data, tl[cyc].rdata);
            chk("resp_miss", 64'(resp_miss), 64'(tl[cyc].rmiss));
            chk("resp_err", 64'(resp_err), 64'(tl[cyc].rerr));
         end
      end
   end
   // rk: WAIT cycle (1-based) in which the set replies with miss/dr; 0 = never.
   // hold: RESP cycles with resp_ready low before it is raised.
   // noise: drive miss and data_ready high outside WAIT, which must be ignored.
   task automatic run_op(input logic [31:0] addr, input bit we, input logic [1:0] size,
                         input logic [63:0] wdata, input int rk, input bit miss, input bit dr,
                         input logic [63:0] rdata, input int hold, input bit noise);
      int          p, w, r0, fin, k;
      bit          mis, in_wait, rep;
      logic [63:0] e_data;
      bit          e_miss, e_err;
      p = cyc;
      mis = int'(addr[5:0]) + (1 << size) > 64;
      rep = rk >= 1 && rk <= TIMEOUT;
      w = we ? 1 : rep ? rk : TIMEOUT;
      e_data = '0;
      e_miss = 1'b0;
      e_err = 1'b0;
      if (mis) e_err = 1'b1;
      else if (we) e_miss = rk == 1 && miss;
      else if (rep && miss) e_miss = 1'b1;
      else if (rep && dr) e_data = rdata;
      else e_err = 1'b1;
      r0 = mis ? p + 1 : p + 2 + w;
      fin = r0 + hold;
      tl[p].v = 1'b1;
      tl[p].busy = 1'b0;
      tl[p].ready = 1'b1;
      tl[p].rvalid = 1'b0;
      tl[p].en = '0;
      tl[p].we = 3'd2;
      tl[p].nops = m_nops;
      m_nops = m_nops + 32'd1;
      for (int c = p + 1; c <= fin; c++) begin
         tl[c].v = 1'b1;
         tl[c].busy = 1'b1;
         tl[c].ready = 1'b0;
         tl[c].rvalid = c >= r0;
         tl[c].en = (!mis && c == p + 1) ? 4'd1 << addr[7:6] : 4'd0;
         tl[c].we = (!mis && c == p + 1) ? {2'b00, we} : 3'd2;
         tl[c].nops = m_nops;
         tl[c].tag = addr[31:8];
         tl[c].off = addr[5:0];
         tl[c].size = size;
         tl[c].wdata = wdata;
         tl[c].rdata = e_data;
         tl[c].rmiss = e_miss;
         tl[c].rerr = e_err;
      end
      cap_lat = -1;
      cap_en = '0;
      cap_we = 3'd2;
      cap_tag = '0;
      cap_data = '1;
      cap_miss = 1'bx;
      cap_err = 1'bx;
      req_valid = 1'b1;
      req_addr = addr;
      req_we = we;
      req_size = size;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
      req_addr = 32'hDEAD_BEEF;
      req_we = ~we;
      req_size = ~size;
      req_wdata = ~wdata;
      for (int c = p + 1; c <= fin; c++) begin
         k = c - p - 1;
         in_wait = !mis && k >= 1 && k <= w;
         if (in_wait && k == rk) begin
            set_miss = miss;
            set_data_ready = dr;
            set_out_data = rdata;
         end else if (noise && !in_wait) begin
            set_miss = 1'b1;
            set_data_ready = 1'b1;
            set_out_data = 64'hBAD0_BAD0_BAD0_BAD0;
         end else begin
            set_miss = 1'b0;
            set_data_ready = 1'b0;
            set_out_data = 64'hFEED_FACE_FEED_FACE;
         end
         resp_ready = c == fin;
         if (resp_valid && cap_lat < 0) begin
            cap_lat = c - p;
            cap_data = resp_data;
            cap_miss = resp_miss;
            cap_err = resp_err;
         end
         if (set_enable != '0) begin
            cap_en = set_enable;
            cap_we = set_write_enable;
            cap_tag = set_tag;
         end
         tick();
      end
      set_miss = 1'b0;
      set_data_ready = 1'b0;
      resp_ready = 1'b0;
   endtask
   initial begin
      int p;
      repeat (3) tick();
      chk("rst req_ready", 64'(req_ready), 64'd1);
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst set_enable", 64'(set_enable), 64'd0);
      chk("rst set_write_enable", 64'(set_write_enable), 64'd2);
      chk("rst set_n_ops", 64'(set_n_ops), 64'd0);
      chk("rst resp_data", resp_data, 64'd0);
      chk("rst resp_err", 64'(resp_err), 64'd0);
      chk("rst set_tag", 64'(set_tag), 64'd0);
      rst_n = 1'b1;
      tick();
      // write hit, immediate completion
      run_op(32'h0000_0F00, 1'b1, 2'd3, 64'h1122334455667788, 1, 1'b0, 1'b0, '0, 0, 1'b0);
      chk("wr latency", 64'(cap_lat), 64'd3);
      chk("wr enable", 64'(cap_en), 64'h1);
      chk("wr write_enable", 64'(cap_we), 64'd1);
      chk("wr tag", 64'(cap_tag), 64'h00000F);
      chk("wr miss", 64'(cap_miss), 64'd0);
      chk("wr err", 64'(cap_err), 64'd0);
      // read, data on 2nd WAIT cycle
      run_op(32'h0000_0F00, 1'b0, 2'd3, '0, 2, 1'b0, 1'b1, 64'h1122334455667788, 1, 1'b0);
      chk("rd latency", 64'(cap_lat), 64'd4);
      chk("rd data", cap_data, 64'h1122334455667788);
      chk("rd write_enable", 64'(cap_we), 64'd0);
      chk("rd err", 64'(cap_err), 64'd0);
      // miss and data_ready together: miss wins
      run_op(32'h0000_1340, 1'b0, 2'd2, '0, 1, 1'b1, 1'b1, 64'hCAFE_CAFE_CAFE_CAFE, 0, 1'b0);
      chk("miss enable", 64'(cap_en), 64'h2);
      chk("miss tag", 64'(cap_tag), 64'h13);
      chk("miss flag", 64'(cap_miss), 64'd1);
      chk("miss data", cap_data, 64'd0);
      // misaligned
      run_op(32'h0000_0F3C, 1'b0, 2'd3, '0, 1, 1'b0, 1'b1, 64'h1, 0, 1'b0);
      chk("mis latency", 64'(cap_lat), 64'd1);
      chk("mis err", 64'(cap_err), 64'd1);
      chk("mis enable", 64'(cap_en), 64'd0);
      chk("mis n_ops", 64'(set_n_ops), 64'd4);
      // timeout with a stalled response
      run_op(32'h0000_0080, 1'b0, 2'd2, '0, 0, 1'b0, 1'b0, '0, 5, 1'b0);
      chk("to latency", 64'(cap_lat), 64'd10);
      chk("to err", 64'(cap_err), 64'd1);
      chk("to data", cap_data, 64'd0);
      // reply exactly on the last permitted WAIT cycle
      run_op(32'h0000_00C8, 1'b0, 2'd1, '0, TIMEOUT, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 2, 1'b0);
      chk("edge latency", 64'(cap_lat), 64'd10);
      chk("edge data", cap_data, 64'h0123_4567_89AB_CDEF);
      chk("edge err", 64'(cap_err), 64'd0);
      // offset boundaries
      run_op(32'h0000_0038, 1'b0, 2'd3, '0, 1, 1'b0, 1'b1, 64'h5555_AAAA_5555_AAAA, 0, 1'b0);
      chk("b64 err", 64'(cap_err), 64'd0);
      run_op(32'h0000_003F, 1'b1, 2'd0, 64'hAB, 1, 1'b1, 1'b0, '0, 1, 1'b0);
      chk("b1 wr miss", 64'(cap_miss), 64'd1);
      run_op(32'h0000_003F, 1'b1, 2'd1, 64'hABCD, 1, 1'b0, 1'b0, '0, 0, 1'b0);
      chk("b2 wr err", 64'(cap_err), 64'd1);
      // late replies outside WAIT must be ignored
      run_op(32'h0000_0204, 1'b1, 2'd2, 64'h0000_0000_DEAD_0001, 1, 1'b0, 1'b0, '0, 2, 1'b1);
      chk("noise wr miss", 64'(cap_miss), 64'd0);
      run_op(32'h0000_01C8, 1'b0, 2'd2, '0, 3, 1'b0, 1'b1, 64'h7777_0000_1111_2222, 2, 1'b1);
      chk("noise rd enable", 64'(cap_en), 64'h8);
      chk("noise rd data", cap_data, 64'h7777_0000_1111_2222);
      // reset in the 3rd WAIT cycle
      p = cyc;
      req_valid = 1'b1;
      req_addr = 32'h0000_0100;
      req_we = 1'b0;
      req_size = 2'd2;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      chk("mid-wait busy", 64'(req_ready), 64'd0);
      chk("mid-wait cyc", 64'(cyc - p), 64'd4);
      rst_n = 1'b0;
      tick();
      chk("post-rst req_ready", 64'(req_ready), 64'd1);
      chk("post-rst resp_valid", 64'(resp_valid), 64'd0);
      chk("post-rst n_ops", 64'(set_n_ops), 64'd0);
      chk("post-rst enable", 64'(set_enable), 64'd0);
      chk("post-rst write_enable", 64'(set_write_enable), 64'd2);
      rst_n = 1'b1;
      m_nops = '0;
      tick();
      chk("post-rst idle", 64'(resp_valid), 64'd0);
      run_op(32'h0000_0F00, 1'b1, 2'd3, 64'h99, 1, 1'b0, 1'b0, '0, 0, 1'b0);
      chk("post-rst op n_ops", 64'(set_n_ops), 64'd1);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
